// File: rtl/fetch_if.sv
// Bus between the fetch unit and its environment: start/redirect control,
// instruction-memory port, decoder handshake and status.
interface fetch_if #(
   parameter int unsigned PC_WIDTH = 8
);
   logic                start;
   logic [PC_WIDTH-1:0] imem_addr;
   logic                imem_rd_en;
   logic [15:0]         imem_rdata;
   logic [15:0]         instr;
   logic                instr_valid;
   logic                instr_ready;
   logic                redirect;
   logic [PC_WIDTH-1:0] redirect_addr;
   logic [PC_WIDTH-1:0] pc;
   logic                halted;

   modport master (
      input  start, imem_rdata, instr_ready, redirect, redirect_addr,
      output imem_addr, imem_rd_en, instr, instr_valid, pc, halted
   );

   modport slave (
      output start, imem_rdata, instr_ready, redirect, redirect_addr,
      input  imem_addr, imem_rd_en, instr, instr_valid, pc, halted
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one-cycle reads at pc, captures the returned
// word and holds it for the decoder until accepted, honouring redirects and HALT.
module fetch_unit #(
   parameter int unsigned         PC_WIDTH    = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [2:0]          HALT_OPCODE = 3'b111
) (
   input logic     clk,
   input logic     rst_n,
   fetch_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      VALID,
      HALTED
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]         instr_q, instr_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // Redirect outranks everything except HALTED; in VALID an acceptance in the
   // same cycle still completes, but the redirect decides where we go next.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         IDLE: begin
            if (bus.redirect) begin
               pc_d = bus.redirect_addr;
            end else if (bus.start) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (bus.redirect) begin
               pc_d    = bus.redirect_addr;
               state_d = FETCH;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.redirect) begin
               pc_d    = bus.redirect_addr;
               state_d = FETCH;
            end else begin
               instr_d = bus.imem_rdata;
               pc_d    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
               state_d = VALID;
            end
         end
         VALID: begin
            if (bus.redirect) begin
               pc_d    = bus.redirect_addr;
               state_d = FETCH;
            end else if (bus.instr_ready) begin
               state_d = (instr_q[15:13] == HALT_OPCODE) ? HALTED : FETCH;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.imem_addr   = pc_q;
   assign bus.pc          = pc_q;
   assign bus.instr       = instr_q;
   assign bus.imem_rd_en  = (state_q == FETCH);
   assign bus.instr_valid = (state_q == VALID);
   assign bus.halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (RESET_PC=8'hFF): expected read addresses and
// accepted instructions are queued by the stimulus and checked by a monitor.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst_n;

   int assertions = 0;
   int failures   = 0;

   logic [15:0] mem [256];
   logic [7:0]  exp_addr_q [$];
   logic [15:0] exp_instr_q [$];

   logic [15:0] seq_instr [3];

   fetch_if #(.PC_WIDTH(8)) bus ();

   fetch_unit #(
      .PC_WIDTH    (8),
      .RESET_PC    (8'hFF),
      .HALT_OPCODE (3'b111)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory returns data the cycle after a read; idle cycles return a marker word.
   always @(posedge clk) begin
      bus.imem_rdata <= bus.imem_rd_en ? mem[bus.imem_addr] : 16'hDEAD;
   end

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
      end
   endtask

   task automatic reportUnexpected(input string name, input logic [15:0] actual);
      assertions++;
      failures++;
      $display("[TB] FAIL %s: actual %h, required none", name, actual);
   endtask

   task automatic applyStimulus(input logic start, input logic ready,
                                input logic redirect, input logic [7:0] raddr);
      bus.start         = start;
      bus.instr_ready   = ready;
      bus.redirect      = redirect;
      bus.redirect_addr = raddr;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (bus.imem_rd_en === 1'b1) begin
         if (exp_addr_q.size() == 0)
            reportUnexpected("unexpected_read", {8'h00, bus.imem_addr});
         else
            checkOutput("read_addr", {8'h00, bus.imem_addr}, {8'h00, exp_addr_q.pop_front()});
      end
      if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
         if (exp_instr_q.size() == 0)
            reportUnexpected("unexpected_accept", bus.instr);
         else
            checkOutput("accepted_instr", bus.instr, exp_instr_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: actual timeout, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h00] = 16'h1518;
      mem[8'h01] = 16'h2CA0;
      mem[8'h02] = 16'hE000;
      mem[8'hFF] = 16'h3123;
      mem[8'h20] = 16'hBC7F;
      mem[8'h21] = 16'h6666;
      mem[8'h40] = 16'h4A55;
      mem[8'h41] = 16'h7ABC;
      mem[8'h30] = 16'hE123;
      mem[8'h10] = 16'h5555;
      seq_instr[0] = 16'h1518;
      seq_instr[1] = 16'h2CA0;
      seq_instr[2] = 16'hE000;

      // Reset held with every control input active
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h55);
      tick(3);
      checkOutput("rst_pc", {8'h00, bus.pc}, 16'h00FF);
      checkOutput("rst_imem_addr", {8'h00, bus.imem_addr}, 16'h00FF);
      checkOutput("rst_instr", bus.instr, 16'h0000);
      checkOutput("rst_valid", {15'h0, bus.instr_valid}, 16'h0);
      checkOutput("rst_rd_en", {15'h0, bus.imem_rd_en}, 16'h0);
      checkOutput("rst_halted", {15'h0, bus.halted}, 16'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      tick(1);
      checkOutput("idle_pc", {8'h00, bus.pc}, 16'h00FF);

      // Wrap from 8'hFF, then the ADD/SUB/HALT program at full throughput
      exp_addr_q.push_back(8'hFF);
      exp_addr_q.push_back(8'h00);
      exp_addr_q.push_back(8'h01);
      exp_addr_q.push_back(8'h02);
      exp_instr_q.push_back(16'h3123);
      for (int k = 0; k < 3; k++) exp_instr_q.push_back(seq_instr[k]);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      tick(1);
      checkOutput("first_rd_en", {15'h0, bus.imem_rd_en}, 16'h1);
      checkOutput("first_addr", {8'h00, bus.imem_addr}, 16'h00FF);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      tick(1);
      checkOutput("wait_valid", {15'h0, bus.instr_valid}, 16'h0);
      checkOutput("wait_instr", bus.instr, 16'h0000);
      tick(1);
      checkOutput("wrap_valid", {15'h0, bus.instr_valid}, 16'h1);
      checkOutput("wrap_instr", bus.instr, 16'h3123);
      checkOutput("wrap_pc", {8'h00, bus.pc}, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         tick(3);
         checkOutput("seq_valid", {15'h0, bus.instr_valid}, 16'h1);
         checkOutput("seq_instr", bus.instr, seq_instr[k]);
         checkOutput("seq_pc", {8'h00, bus.pc}, 16'(k + 1));
      end
      tick(1);
      checkOutput("halt_halted", {15'h0, bus.halted}, 16'h1);
      checkOutput("halt_pc", {8'h00, bus.pc}, 16'h0003);
      checkOutput("halt_valid", {15'h0, bus.instr_valid}, 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h77);
      tick(4);
      checkOutput("halt_sticky", {15'h0, bus.halted}, 16'h1);
      checkOutput("halt_ignores_redirect", {8'h00, bus.pc}, 16'h0003);

      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      checkOutput("rerst_pc", {8'h00, bus.pc}, 16'h00FF);
      checkOutput("rerst_halted", {15'h0, bus.halted}, 16'h0);

      // Redirect while idle only moves pc
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h20);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("idle_redirect_pc", {8'h00, bus.pc}, 16'h0020);
      checkOutput("idle_redirect_rd_en", {15'h0, bus.imem_rd_en}, 16'h0);
      tick(2);
      checkOutput("idle_redirect_stay", {8'h00, bus.pc}, 16'h0020);

      // Backpressure: hold BC7F for five cycles
      exp_addr_q.push_back(8'h20);
      exp_addr_q.push_back(8'h21);
      exp_instr_q.push_back(16'hBC7F);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      tick(2);
      checkOutput("bp_instr", bus.instr, 16'hBC7F);
      for (int k = 0; k < 5; k++) begin
         tick(1);
         checkOutput("bp_valid", {15'h0, bus.instr_valid}, 16'h1);
         checkOutput("bp_stable", bus.instr, 16'hBC7F);
         checkOutput("bp_pc", {8'h00, bus.pc}, 16'h0021);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      tick(1);

      // Redirect in WAIT: word from 8'h21 must never be presented
      exp_addr_q.push_back(8'h40);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h40);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("redir_valid", {15'h0, bus.instr_valid}, 16'h0);
      checkOutput("redir_no_capture", bus.instr, 16'hBC7F);
      checkOutput("redir_rd_en", {15'h0, bus.imem_rd_en}, 16'h1);
      checkOutput("redir_addr", {8'h00, bus.imem_addr}, 16'h0040);
      tick(2);
      checkOutput("redir_instr", bus.instr, 16'h4A55);
      exp_instr_q.push_back(16'h4A55);
      exp_addr_q.push_back(8'h41);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      tick(2);
      checkOutput("pre_reset_valid", {15'h0, bus.instr_valid}, 16'h1);
      checkOutput("pre_reset_instr", bus.instr, 16'h7ABC);

      // Reset while VALID
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h99);
      tick(1);
      checkOutput("midrst_pc", {8'h00, bus.pc}, 16'h00FF);
      checkOutput("midrst_instr", bus.instr, 16'h0000);
      checkOutput("midrst_valid", {15'h0, bus.instr_valid}, 16'h0);
      checkOutput("midrst_rd_en", {15'h0, bus.imem_rd_en}, 16'h0);
      tick(1);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      tick(3);
      checkOutput("post_rst_idle_valid", {15'h0, bus.instr_valid}, 16'h0);
      checkOutput("post_rst_idle_pc", {8'h00, bus.pc}, 16'h00FF);

      // Redirect together with acceptance of HALT
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h30);
      tick(1);
      exp_addr_q.push_back(8'h30);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      tick(2);
      checkOutput("halt_held", bus.instr, 16'hE123);
      checkOutput("halt_held_valid", {15'h0, bus.instr_valid}, 16'h1);
      exp_instr_q.push_back(16'hE123);
      exp_addr_q.push_back(8'h10);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h10);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("redir_accept_halted", {15'h0, bus.halted}, 16'h0);
      checkOutput("redir_accept_rd_en", {15'h0, bus.imem_rd_en}, 16'h1);
      checkOutput("redir_accept_addr", {8'h00, bus.imem_addr}, 16'h0010);
      tick(2);
      checkOutput("redir_accept_instr", bus.instr, 16'h5555);
      exp_instr_q.push_back(16'h5555);
      exp_addr_q.push_back(8'h11);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b0;
      tick(2);

      checkOutput("pending_reads", 16'(exp_addr_q.size()), 16'h0);
      checkOutput("pending_instrs", 16'(exp_instr_q.size()), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8: width of the program counter and instruction-memory address.
REQ-002 Parameter RESET_PC, default 0: program counter value loaded on reset.
REQ-003 Parameter HALT_OPCODE, default 3'b111: opcode in instr[15:13] that stops fetching.
REQ-004 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  level; when high in IDLE, begins fetching at the current pc.
REQ-007 imem_addr  out  PC_WIDTH  instruction-memory address; always equals pc.
REQ-008 imem_rd_en  out  1  instruction-memory read strobe.
REQ-009 imem_rdata  in  16  instruction word; valid the cycle after the cycle in which imem_rd_en is high.
REQ-010 instr  out  16  registered instruction presented to the decoder: opcode [15:13], dest [12:10], src1 [9:7], src2 [6:4], immediate [7:0].
REQ-011 instr_valid  out  1  instr holds an instruction not yet accepted.
REQ-012 instr_ready  in  1  decoder/execute accepts instr when instr_valid and instr_ready are both high.
REQ-013 redirect  in  1  one-cycle request to resume fetching at redirect_addr.
REQ-014 redirect_addr  in  PC_WIDTH  target address for redirect.
REQ-015 pc  out  PC_WIDTH  address of the next word to fetch.
REQ-016 halted  out  1  high in HALTED.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, FETCH, WAIT, VALID and HALTED.
REQ-018 IDLE: when start=1, go to FETCH; otherwise stay.
REQ-019 FETCH: drive imem_rd_en=1 for exactly this one cycle, then go to WAIT.
REQ-020 WAIT: at the closing edge, capture instr<=imem_rdata, update pc<=pc+1, and go to VALID.
REQ-021 VALID: drive instr_valid=1 and hold instr stable until it is accepted.
REQ-022 On acceptance in VALID: go to HALTED if instr[15:13]==HALT_OPCODE; otherwise go to FETCH.
REQ-023 HALTED: stay until reset; ignore start and redirect; keep imem_rd_en=0 and instr_valid=0.
REQ-024 Timing: start sampled high at edge N gives imem_rd_en high between edges N and N+1, and instr_valid high from edge N+2.
REQ-025 Throughput: with instr_ready tied high, one instruction is accepted every 3 cycles.
REQ-026 pc increment wraps modulo 2^PC_WIDTH, so 8'hFF+1 gives 8'h00.
REQ-027 A redirect sampled in FETCH, WAIT or VALID SHALL:
  - load pc<=redirect_addr;
  - discard any in-flight or held instruction (no instr capture, instr_valid low from the next cycle);
  - go to FETCH.
REQ-028 Redirect in IDLE SHALL load pc<=redirect_addr and stay in IDLE.
REQ-029 Simultaneous redirect and acceptance in VALID: the acceptance completes, then redirect applies (pc<=redirect_addr, go to FETCH), even if the accepted instruction is HALT.
REQ-030 imem_rd_en SHALL be high only in FETCH, and instr_valid only in VALID.
REQ-031 instr SHALL change only in WAIT (capture) or on reset.

Reset
REQ-032 With rst_n low at a rising edge:
  - state<=IDLE, pc<=RESET_PC, instr<=16'h0000;
  - instr_valid, imem_rd_en and halted all 0.
REQ-033 Reset mid-operation (any state) SHALL take effect at the next edge; the in-flight read is discarded and no instr_valid pulse follows.
REQ-034 Outputs SHALL hold their reset values while rst_n stays low, regardless of start, redirect or instr_ready.

Verification
REQ-035 Sequential fetch. Memory [0]=16'h1518 (ADD), [1]=16'h2CA0 (SUB), [2]=16'hE000 (HALT); start=1; ready=1.
  -> instr 1518, 2CA0 and E000 accepted at 3-cycle spacing; pc ends at 3; halted=1; no further imem_rd_en.
REQ-036 Backpressure. Hold instr_ready=0 for 5 cycles in VALID with instr=16'hBC7F.
  -> instr_valid stays 1; instr is stable at BC7F; no imem_rd_en; pc unchanged.
REQ-037 Redirect. Assert redirect in WAIT with redirect_addr=8'h40.
  -> the word being returned is never presented; the next imem_rd_en has imem_addr=8'h40; the next accepted instr is mem[8'h40].
REQ-038 Wrap-around. After reset with RESET_PC=8'hFF, fetch one non-HALT instruction.
  -> imem_addr=8'hFF on the first read; pc=8'h00 after capture; the next read is at 8'h00.
REQ-039 Reset mid-operation. Drive rst_n low in VALID.
  -> next cycle: state IDLE, pc=RESET_PC, instr=0000, instr_valid=0; nothing fetched until start.
REQ-040 Redirect with acceptance. Assert redirect and instr_ready together in VALID, holding HALT, with redirect_addr=8'h10.
  -> halted stays 0; the next read is at 8'h10.
